// File: rtl/inst_fetch_bridge_pkg.sv
// Shared definitions for the instruction-fetch bridge.
//   fetch_state_t    : 2-bit fetch FSM encoding (IDLE/REQ/WAIT/ERR)
//   NOP_INST_DEFAULT : instruction returned whenever inst is not valid
//   LINE_OFF_W       : byte-offset width of one 64-bit line
//   select_word      : picks the 32-bit half of a line addressed by bit 2
package inst_fetch_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ERR  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;
    localparam int          LINE_OFF_W       = 3;

    function automatic logic [31:0] select_word(input logic [63:0] line, input logic upper);
        return upper ? line[63:32] : line[31:0];
    endfunction

endpackage

// File: rtl/inst_fetch_bridge_fetch_line_buf.sv
// Single-entry 64-bit instruction line buffer.
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : invalidate the line at the next edge (wins over fill)
//   fill          : write fill_tag/fill_data and mark the line valid
//   lookup_tag    : doubleword tag of the current fetch address
//   lookup_upper  : fetch address bit 2 (selects the upper word)
//   tag_match     : line is valid and holds lookup_tag
//   word          : selected 32-bit half of the stored line
module fetch_line_buf
    import inst_fetch_bridge_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       fill,
    input  logic [ADDR_W-LINE_OFF_W-1:0] fill_tag,
    input  logic [63:0]                fill_data,
    input  logic [ADDR_W-LINE_OFF_W-1:0] lookup_tag,
    input  logic                       lookup_upper,
    output logic                       tag_match,
    output logic [31:0]                word
);

    logic                         line_valid_reg;
    logic [ADDR_W-LINE_OFF_W-1:0] line_tag_reg;
    logic [63:0]                  line_data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_valid_reg <= 1'b0;
            line_tag_reg   <= '0;
            line_data_reg  <= '0;
        end else if (clear) begin
            line_valid_reg <= 1'b0;
        end else if (fill) begin
            line_valid_reg <= 1'b1;
            line_tag_reg   <= fill_tag;
            line_data_reg  <= fill_data;
        end
    end

    assign tag_match = line_valid_reg && (lookup_tag == line_tag_reg);
    assign word      = select_word(line_data_reg, lookup_upper);

endmodule

// File: rtl/inst_fetch_bridge.sv
// Instruction-fetch bridge between the core fetch port and a variable-latency
// memory with a valid/ready request channel and a valid-only response channel.
//   clk, rst                         : clock, asynchronous active-high reset
//   inst_ena, inst_addr, flush       : core fetch request / line invalidate
//   inst, inst_valid, if_stall       : fetched word, its validity, core hold
//   fetch_err, fetch_misalign        : bus error or timeout / misaligned PC
//   mem_req_valid/ready/addr         : doubleword read request channel
//   mem_rsp_valid/data/err           : single-cycle response channel
module inst_fetch_bridge
    import inst_fetch_bridge_pkg::*;
#(
    parameter int          ADDR_W   = 64,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_ena,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              flush,
    output logic [31:0]       inst,
    output logic              inst_valid,
    output logic              if_stall,
    output logic              fetch_err,
    output logic              fetch_misalign,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [63:0]       mem_rsp_data,
    input  logic              mem_rsp_err
);

    localparam int TAG_W = ADDR_W - LINE_OFF_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    fetch_state_t      state_reg, state_next;
    logic [CNT_W-1:0]  wait_cnt_reg;
    logic              discard_reg;
    logic [ADDR_W-1:0] req_addr_reg;

    logic              aligned;
    logic              tag_match;
    logic [31:0]       line_word;
    logic              hit;
    logic              miss;
    logic              timeout_hit;
    logic              rsp_dropped;
    logic              fill;
    logic              err_accept;

    assign aligned     = (inst_addr[1:0] == 2'b00);
    assign hit         = (state_reg == ST_IDLE) && inst_ena && aligned && tag_match;
    assign miss        = inst_ena && aligned && !tag_match;
    // wait_cnt_reg counts completed WAIT cycles, so this is the TIMEOUT-th one.
    assign timeout_hit = (wait_cnt_reg == CNT_W'(TIMEOUT - 1));
    // A response is thrown away if the fetch was abandoned earlier or right now.
    assign rsp_dropped = discard_reg || flush;
    assign fill        = (state_reg == ST_WAIT) && mem_rsp_valid && !mem_rsp_err && !rsp_dropped;
    assign err_accept  = (state_reg == ST_WAIT) && mem_rsp_valid && mem_rsp_err && !rsp_dropped;

    fetch_line_buf #(
        .ADDR_W(ADDR_W)
    ) u_line_buf (
        .clk         (clk),
        .rst         (rst),
        .clear       (flush || err_accept),
        .fill        (fill),
        .fill_tag    (req_addr_reg[ADDR_W-1:LINE_OFF_W]),
        .fill_data   (mem_rsp_data),
        .lookup_tag  (inst_addr[ADDR_W-1:LINE_OFF_W]),
        .lookup_upper(inst_addr[2]),
        .tag_match   (tag_match),
        .word        (line_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr_reg <= '0;
            wait_cnt_reg <= '0;
            discard_reg  <= 1'b0;
        end else begin
            if ((state_reg == ST_IDLE) && miss) begin
                req_addr_reg <= {inst_addr[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
            end
            if ((state_reg == ST_REQ) && mem_req_ready) begin
                wait_cnt_reg <= '0;
                // A flush coinciding with the handshake cannot retract the
                // request, so remember to drop its response.
                discard_reg  <= flush;
            end else if (state_reg == ST_WAIT) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
                if (state_next != ST_WAIT) begin
                    discard_reg <= 1'b0;
                end else if (flush) begin
                    discard_reg <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        inst           = NOP_INST;
        inst_valid     = 1'b0;
        if_stall       = 1'b0;
        fetch_err      = 1'b0;
        fetch_misalign = 1'b0;
        mem_req_valid  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (miss) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_next = ST_WAIT;
                end else if (flush) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    state_next = (mem_rsp_err && !rsp_dropped) ? ST_ERR : ST_IDLE;
                end else if (timeout_hit) begin
                    state_next = ST_ERR;
                end
            end
            ST_ERR: begin
                // No retry: leave only when the core moves to another line or flushes.
                if (flush || (inst_addr[ADDR_W-1:LINE_OFF_W] != req_addr_reg[ADDR_W-1:LINE_OFF_W])) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Outputs fall to their idle values for as long as reset is held.
        if (!rst) begin
            fetch_misalign = inst_ena && !aligned;
            case (state_reg)
                ST_IDLE: begin
                    inst_valid = hit;
                    if (hit) begin
                        inst = line_word;
                    end
                    if_stall = miss;
                end
                ST_REQ: begin
                    mem_req_valid = 1'b1;
                    if_stall      = inst_ena && aligned;
                end
                ST_WAIT: begin
                    if_stall = inst_ena && aligned;
                end
                ST_ERR: begin
                    fetch_err = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_req_addr = req_addr_reg;

endmodule

// File: tb/tb_inst_fetch_bridge.sv
module tb_inst_fetch_bridge;

    localparam int          ADDR_W  = 64;
    localparam int          TIMEOUT = 8;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_ena = 1'b0;
    logic [63:0] inst_addr = '0;
    logic        flush = 1'b0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        if_stall;
    logic        fetch_err;
    logic        fetch_misalign;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_data = '0;
    logic        mem_rsp_err = 1'b0;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;

    always #5 clk = ~clk;

    inst_fetch_bridge #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT),
        .NOP_INST(NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_ena      (inst_ena),
        .inst_addr     (inst_addr),
        .flush         (flush),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .if_stall      (if_stall),
        .fetch_err     (fetch_err),
        .fetch_misalign(fetch_misalign),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err)
    );

    task automatic chkw(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: a line, a request waiting for acceptance,
    // a request in flight (with elapsed wait cycles and a drop flag), and a
    // sticky failed line.
    bit          m_line_v = 1'b0;
    logic [60:0] m_line_tag = '0;
    logic [63:0] m_line_data = '0;
    bit          m_pend = 1'b0;
    logic [63:0] m_req_addr = '0;
    bit          m_fly = 1'b0;
    int          m_wcnt = 0;
    bit          m_drop = 1'b0;
    bit          m_err = 1'b0;
    logic [60:0] m_err_line = '0;

    always @(negedge clk) begin : compare
        logic        aligned;
        logic        busy;
        logic        idle;
        logic        hit;
        logic        e_stall;
        logic        e_mis;
        logic [31:0] e_inst;
        logic [60:0] tag;

        if (rst) begin
            m_line_v = 0; m_line_tag = '0; m_line_data = '0;
            m_pend = 0; m_req_addr = '0; m_fly = 0; m_wcnt = 0;
            m_drop = 0; m_err = 0; m_err_line = '0;
        end

        tag     = inst_addr[63:3];
        aligned = (inst_addr[1:0] == 2'b00);
        busy    = m_pend || m_fly;
        idle    = !busy && !m_err;
        hit     = !rst && inst_ena && aligned && idle && m_line_v && (tag == m_line_tag);
        e_inst  = hit ? (inst_addr[2] ? m_line_data[63:32] : m_line_data[31:0]) : NOP;
        e_stall = !rst && inst_ena && aligned && (busy || (idle && !hit));
        e_mis   = !rst && inst_ena && !aligned;

        chkw("m_inst", 64'(inst), 64'(e_inst));
        chk1("m_inst_valid", inst_valid, hit);
        chk1("m_if_stall", if_stall, e_stall);
        chk1("m_fetch_err", fetch_err, !rst && m_err);
        chk1("m_misalign", fetch_misalign, e_mis);
        chk1("m_req_valid", mem_req_valid, !rst && m_pend);
        chkw("m_req_addr", mem_req_addr, m_req_addr);

        if (!rst && mem_req_valid && mem_req_ready) hs_count++;

        if (!rst) begin
            if (m_err) begin
                if (flush || tag != m_err_line) m_err = 0;
            end else if (m_fly) begin
                m_wcnt++;
                if (mem_rsp_valid) begin
                    m_fly = 0;
                    if (!flush && !m_drop) begin
                        if (mem_rsp_err) begin
                            m_err = 1; m_err_line = m_req_addr[63:3]; m_line_v = 0;
                        end else begin
                            m_line_v = 1; m_line_tag = m_req_addr[63:3]; m_line_data = mem_rsp_data;
                        end
                    end
                    m_drop = 0;
                end else if (m_wcnt == TIMEOUT) begin
                    m_fly = 0; m_drop = 0; m_err = 1; m_err_line = m_req_addr[63:3];
                end else if (flush) begin
                    m_drop = 1;
                end
            end else if (m_pend) begin
                if (mem_req_ready) begin
                    m_pend = 0; m_fly = 1; m_wcnt = 0; m_drop = flush;
                end else if (flush) begin
                    m_pend = 0;
                end
            end else if (inst_ena && aligned && !hit) begin
                m_pend = 1; m_req_addr = {tag, 3'b000};
            end
            if (flush) m_line_v = 0;
        end
    end

    initial begin : stim
        int hs0;

        // Reset values
        step(); step();
        chkw("rst_inst", 64'(inst), 64'(NOP));
        chk1("rst_valid", inst_valid, 1'b0);
        chk1("rst_stall", if_stall, 1'b0);
        chk1("rst_req_valid", mem_req_valid, 1'b0);
        chkw("rst_req_addr", mem_req_addr, 64'h0);
        chk1("rst_err", fetch_err, 1'b0);
        step();
        rst = 1'b0;

        // Cold fetch: three stall cycles, then hit; neighbouring word hits
        inst_ena = 1'b1; inst_addr = 64'h8000_0000; mem_req_ready = 1'b1; #1;
        chk1("s1_stall0", if_stall, 1'b1);
        chk1("s1_noreq0", mem_req_valid, 1'b0);
        step(); #1;
        chk1("s1_stall1", if_stall, 1'b1);
        chk1("s1_req_valid", mem_req_valid, 1'b1);
        chkw("s1_req_addr", mem_req_addr, 64'h8000_0000);
        step();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'h00A0_0093_0000_0513; #1;
        chk1("s1_stall2", if_stall, 1'b1);
        step();
        mem_rsp_valid = 1'b0; #1;
        chk1("s1_hit_valid", inst_valid, 1'b1);
        chkw("s1_hit_inst", 64'(inst), 64'h0000_0513);
        chk1("s1_hit_stall", if_stall, 1'b0);
        inst_addr = 64'h8000_0004; #1;
        chk1("s1_hit4_valid", inst_valid, 1'b1);
        chkw("s1_hit4_inst", 64'(inst), 64'h00A0_0093);
        chk1("s1_hit4_noreq", mem_req_valid, 1'b0);
        step();

        // Back-pressure: request held stable for 5 cycles, single handshake
        hs0 = hs_count;
        inst_addr = 64'h8000_0100; #1;
        chk1("s2_stall", if_stall, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            chk1("s2_hold_valid", mem_req_valid, 1'b1);
            chkw("s2_hold_addr", mem_req_addr, 64'h8000_0100);
        end
        step();
        mem_req_ready = 1'b1; #1;
        chk1("s2_hs_valid", mem_req_valid, 1'b1);
        step();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'h1111_2222_3333_4444; #1;
        chk1("s2_wait_stall", if_stall, 1'b1);
        step();
        mem_rsp_valid = 1'b0; #1;
        chk1("s2_fill_valid", inst_valid, 1'b1);
        chkw("s2_fill_inst", 64'(inst), 64'h3333_4444);
        chkw("s2_handshakes", 64'(hs_count - hs0), 64'd1);
        step();

        // Error response: sticky while on the failed line, exits on line change
        inst_addr = 64'h8000_0010; mem_req_ready = 1'b1;
        step();
        step();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_err = 1'b1;
        step();
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; #1;
        chk1("s3_err", fetch_err, 1'b1);
        chk1("s3_err_stall", if_stall, 1'b0);
        chk1("s3_err_valid", inst_valid, 1'b0);
        step();
        inst_addr = 64'h8000_0014; #1;
        chk1("s3_err_hold", fetch_err, 1'b1);
        step();
        inst_addr = 64'h8000_0018;
        step(); #1;
        chk1("s3_exit_err", fetch_err, 1'b0);
        chk1("s3_new_miss", if_stall, 1'b1);
        mem_req_ready = 1'b1;
        step(); #1;
        chk1("s3_new_req", mem_req_valid, 1'b1);
        chkw("s3_new_addr", mem_req_addr, 64'h8000_0018);
        step();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'hCAFE_0001_BEEF_0002;
        step();
        mem_rsp_valid = 1'b0; #1;
        chkw("s3_refill_inst", 64'(inst), 64'hBEEF_0002);
        step();

        // Timeout after TIMEOUT wait cycles; late response ignored
        inst_addr = 64'h8000_0200; mem_req_ready = 1'b1;
        step();
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 7; i++) step();
        #1;
        chk1("s4_last_wait_err", fetch_err, 1'b0);
        chk1("s4_last_wait_stall", if_stall, 1'b1);
        step(); #1;
        chk1("s4_timeout_err", fetch_err, 1'b1);
        chk1("s4_timeout_stall", if_stall, 1'b0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'h0000_0000_DEAD_BEEF;
        step();
        mem_rsp_valid = 1'b0; #1;
        chk1("s4_late_err", fetch_err, 1'b1);
        chk1("s4_late_valid", inst_valid, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0; inst_ena = 1'b0; #1;
        chk1("s4_flush_exit", fetch_err, 1'b0);
        step();

        // Flush during WAIT: response dropped, same address misses again
        inst_ena = 1'b1; inst_addr = 64'h8000_0300; mem_req_ready = 1'b1;
        step();
        step();
        mem_req_ready = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'h5555_6666_7777_8888;
        step();
        mem_rsp_valid = 1'b0; #1;
        chk1("s5_nofill_valid", inst_valid, 1'b0);
        chk1("s5_remiss_stall", if_stall, 1'b1);
        step();
        mem_req_ready = 1'b1; #1;
        chk1("s5_rereq", mem_req_valid, 1'b1);
        step();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'h5555_6666_7777_8888;
        step();
        mem_rsp_valid = 1'b0; #1;
        chkw("s5_fill_inst", 64'(inst), 64'h7777_8888);
        step();

        // Misaligned fetch
        inst_addr = 64'h8000_0002; #1;
        chk1("s6_misalign", fetch_misalign, 1'b1);
        chk1("s6_noreq", mem_req_valid, 1'b0);
        chkw("s6_nop", 64'(inst), 64'(NOP));
        chk1("s6_stall", if_stall, 1'b0);
        step(); #1;
        chk1("s6_noreq_next", mem_req_valid, 1'b0);

        // Asynchronous reset in the middle of a request
        inst_addr = 64'h8000_0400;
        step(); #1;
        chk1("s7_req_before_rst", mem_req_valid, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk1("s7_rst_req_valid", mem_req_valid, 1'b0);
        chkw("s7_rst_req_addr", mem_req_addr, 64'h0);
        chk1("s7_rst_stall", if_stall, 1'b0);
        chkw("s7_rst_inst", 64'(inst), 64'(NOP));
        chk1("s7_rst_valid", inst_valid, 1'b0);
        step();
        rst = 1'b0; inst_ena = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_bridge.md
Name: inst_fetch_bridge

Overview:
- Sits between the core's instruction-fetch port (inst_addr/inst_ena in, 32-bit inst out) and a variable-latency instruction memory with a valid/ready request channel and a valid response channel.
- Holds a single 64-bit line buffer, so sequential fetches within one doubleword hit without a bus access.
- Returns the selected 32-bit word, raises if_stall on a miss, and reports bus errors, timeouts and misaligned fetches.

Parameters:
- ADDR_W, 64, fetch/bus address width
- TIMEOUT, 255, maximum WAIT cycles before a fetch error (counter width = $clog2(TIMEOUT+1))
- NOP_INST, 32'h0000_0013, value driven on inst when inst_valid=0

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- inst_ena  in  1  core requests a fetch this cycle
- inst_addr  in  ADDR_W  fetch PC
- flush  in  1  invalidate the line buffer and abandon any outstanding fetch
- inst  out  32  fetched instruction; NOP_INST when not valid
- inst_valid  out  1  inst is valid for inst_addr this cycle
- if_stall  out  1  core must hold inst_addr
- fetch_err  out  1  bus error or timeout for the current inst_addr
- fetch_misalign  out  1  inst_ena with inst_addr[1:0] != 0
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr  out  ADDR_W  doubleword-aligned address; low 3 bits always 0
- mem_rsp_valid  in  1  response valid (single cycle; no back-pressure)
- mem_rsp_data  in  64  response doubleword
- mem_rsp_err  in  1  response error, qualified by mem_rsp_valid

Behaviour:
- Reset (async):
  - FSM goes to IDLE; line_valid, mem_req_valid, fetch_err, timeout counter, discard flag = 0.
  - mem_req_addr = 0; inst = NOP_INST; inst_valid = if_stall = 0.
- Hit (combinational) is true when inst_ena & line_valid & inst_addr[ADDR_W-1:3]==line_tag & inst_addr[1:0]==0 & FSM in IDLE. On a hit: inst_valid=1; inst = inst_addr[2] ? line_data[63:32] : line_data[31:0]; if_stall=0.
- Misaligned fetch: fetch_misalign=1, inst_valid=0, if_stall=0, no bus request.
- inst_ena=0: inst_valid=0, if_stall=0, no new request. An outstanding request still completes and fills the line.
- FSM states: IDLE, REQ, WAIT, ERR.
  - IDLE: on an aligned miss with inst_ena, capture {inst_addr[ADDR_W-1:3],3'b0} into mem_req_addr, go to REQ. if_stall=1 in the miss cycle.
  - REQ: mem_req_valid=1. Address and valid are held stable until mem_req_ready; on the handshake go to WAIT, clear the timeout counter. if_stall=1.
  - WAIT: counter increments each cycle. if_stall=1 while inst_ena.
    - mem_rsp_valid & !mem_rsp_err & !discard: line_tag/line_data/line_valid written, go to IDLE.
    - mem_rsp_valid & mem_rsp_err: line_valid=0, go to ERR.
    - counter == TIMEOUT: go to ERR.
    - A response with discard set is dropped, discard cleared, go to IDLE.
  - ERR: fetch_err=1, inst_valid=0, if_stall=0. Stays in ERR until flush or until inst_addr[ADDR_W-1:3] differs from the failed line, then goes to IDLE. No automatic retry.
- Minimum miss penalty with zero-latency memory is 3 stall cycles:
  - cycle 0: miss
  - cycle 1: REQ handshake
  - cycle 2: response
  - cycle 3: hit
- flush:
  - Clears line_valid next edge.
  - In REQ: drops mem_req_valid only if not handshaking that cycle; a handshake in the flush cycle sets discard and goes to WAIT.
  - In WAIT: sets discard.
  - In ERR: goes to IDLE.
  - flush has priority over a simultaneous fill, so the fill is dropped.
- mem_rsp_valid outside WAIT is ignored.
- Only one outstanding request at any time.
- Reset mid-transaction aborts immediately. The memory side is reset on the same rst, so no stale response arrives.

Decomposition:
- Shared defines: fetch FSM state encoding (2 bits), NOP_INST, line offset width (3).
- One natural sub-module: fetch_line_buf. It holds the tag/data/valid registers and does the hit compare and word select. The FSM, handshake and timeout logic stay in the parent.

Test Plan:
- Cold fetch from 0x8000_0000, memory ready=1 with 1-cycle response data 0x00A0_0093_0000_0513 -> if_stall high 3 cycles, mem_req_addr=0x8000_0000, then inst=0x0000_0513 valid. Next fetch 0x8000_0004 hits in the same cycle with inst=0x00A0_0093 and no bus request.
- mem_req_ready held low 5 cycles -> mem_req_valid and mem_req_addr stable for all 5 cycles. Exactly one handshake, then fill.
- Response with mem_rsp_err=1 for 0x8000_0010 -> fetch_err=1, if_stall=0, held while addr stays 0x8000_0010/0x8000_0014. Changing addr to 0x8000_0018 returns to IDLE and issues a new request.
- No response for TIMEOUT (set to 8) cycles -> ERR entered on cycle 8 of WAIT; a late response arriving in ERR is ignored.
- flush asserted in WAIT, response arrives next cycle -> line not filled; the next fetch to the same address misses and issues a new request.
- inst_addr=0x8000_0002 with inst_ena -> fetch_misalign=1, no mem_req_valid, inst=0x0000_0013. Async rst pulse mid-REQ -> all outputs at reset values immediately.
